// File: rtl/ht_code_packer.sv
// Packs the encoder's serial code stream into 8-bit words, tags each frame's final word
// with its bit count and frame length, and queues the words behind a valid/ready FIFO.
// Optional build macro HT_PACK_LSB_FIRST_EN selects LSB-first packing (default MSB-first).
module ht_code_packer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_nbits,
  output logic             out_last,
  output logic [CNT_W-1:0] out_frame_bits,
  output logic             err_ovf,
  output logic [0:0]       state_dbg
);

  // Handshake: a word transfers on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the head fields hold until that transfer.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 1 + 4 + CNT_W + 8;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0]       state;
  logic [7:0]       shreg;
  logic [3:0]       fill;
  logic [CNT_W-1:0] frame_cnt;

  logic             capture;
  logic             flush;
  logic             word_full;
  logic [2:0]       pos;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg_nxt;
  logic [CNT_W-1:0] frame_cnt_inc;
  logic             push;
  logic [EW-1:0]    push_entry;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;
  logic [EW-1:0]    head;

  assign state_dbg = state;

  // shreg with fill==8 is the pending word: it is pushed only once we know whether
  // another bit follows (last=0) or the frame ends (last=1).
  always_comb begin
    capture   = in_valid;
    flush     = (state == ST_COLLECT) && !in_valid;
    word_full = (fill == 4'd8);
    pos       = word_full ? 3'd0 : fill[2:0];
`ifdef HT_PACK_LSB_FIRST_EN
    bit_idx   = pos;
`else
    bit_idx   = 3'd7 - pos;
`endif
    shreg_nxt          = word_full ? 8'h00 : shreg;
    shreg_nxt[bit_idx] = in_code;
    frame_cnt_inc = (frame_cnt == {CNT_W{1'b1}}) ? frame_cnt : frame_cnt + 1'b1;

    push       = 1'b0;
    push_entry = '0;
    if (capture && word_full) begin
      push       = 1'b1;
      push_entry = {1'b0, 4'd8, {CNT_W{1'b0}}, shreg};
    end else if (flush) begin
      push       = 1'b1;
      push_entry = {1'b1, fill, frame_cnt, shreg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= 8'h00;
      fill      <= 4'd0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:    if (in_valid)  state <= ST_COLLECT;
        ST_COLLECT: if (!in_valid) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
      if (capture) begin
        shreg     <= shreg_nxt;
        fill      <= word_full ? 4'd1 : fill + 4'd1;
        frame_cnt <= frame_cnt_inc;
      end else if (flush) begin
        shreg     <= 8'h00;
        fill      <= 4'd0;
        frame_cnt <= '0;
      end
    end
  end

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pop        = !fifo_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en      = push && (!fifo_full || pop);
    head       = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) err_ovf <= 1'b1;
    end
  end

  always_comb begin
    out_valid      = !fifo_empty;
    out_last       = 1'b0;
    out_nbits      = 4'd0;
    out_frame_bits = '0;
    out_data       = 8'h00;
    if (!fifo_empty) begin
      {out_last, out_nbits, out_frame_bits, out_data} = head;
    end
  end

endmodule

// File: tb/tb_ht_code_packer.sv
// Directed bench for ht_code_packer (default MSB-first build, FIFO depth 4): frames are
// driven bit by bit, popped words are collected by a monitor and compared to hand-built vectors.
module tb_ht_code_packer;

  localparam int CNT_W = 8;
  localparam int EW    = 1 + 4 + CNT_W + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_code = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [3:0]       out_nbits;
  logic             out_last;
  logic [CNT_W-1:0] out_frame_bits;
  logic             err_ovf;
  logic [0:0]       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  ht_code_packer #(.DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nbits(out_nbits), .out_last(out_last), .out_frame_bits(out_frame_bits),
    .err_ovf(err_ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: a word transfers at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      obs_q.push_back({out_last, out_nbits, out_frame_bits, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      in_valid = 1'b1;
      in_code  = bits[n-1-i];
    end
    tick();
    in_valid = 1'b0;
    in_code  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_word(input logic [7:0] data, input logic [3:0] nbits,
                             input logic last, input logic [CNT_W-1:0] fb);
    exp_q.push_back({last, nbits, fb, data});
  endtask

  // scoreboard: compare everything the monitor saw against the expected queue
  task automatic compare_words(input string tag);
    logic [EW-1:0] o;
    logic [EW-1:0] e;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] held;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_nbits", out_nbits, 4'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_frame_bits", out_frame_bits, 8'd0);
    check("rst_err_ovf", err_ovf, 1'b0);
    check("rst_state", state_dbg, 1'b0);

    // short frame, with frame-end latency
    out_ready = 1'b1;
    send_frame(64'b10110, 5);
    @(posedge clk);
    @(negedge clk);
    check("short_latency_valid", out_valid, 1'b1);
    check("short_latency_data", out_data, 8'hB0);
    expect_word(8'hB0, 4'd5, 1'b1, 8'd5);
    idle(4);
    compare_words("short");

    // exact byte: one word, no trailing empty word
    send_frame(64'b10100101, 8);
    idle(5);
    expect_word(8'hA5, 4'd8, 1'b1, 8'd8);
    compare_words("byte");

    // multi-word frame
    send_frame(64'b11110000_00001111_1010, 20);
    idle(5);
    expect_word(8'hF0, 4'd8, 1'b0, 8'd0);
    expect_word(8'h0F, 4'd8, 1'b0, 8'd0);
    expect_word(8'hA0, 4'd4, 1'b1, 8'd20);
    compare_words("multi");

    // back-to-back frames with a one-cycle gap
    send_frame(64'b1, 1);
    send_frame(64'b01, 2);
    idle(5);
    expect_word(8'h80, 4'd1, 1'b1, 8'd1);
    expect_word(8'h40, 4'd2, 1'b1, 8'd2);
    compare_words("b2b");

    // backpressure and overflow: the flushed fifth word is dropped
    out_ready = 1'b0;
    send_frame({24'h0, 40'hFF_FFFF_FFFF}, 40);
    @(posedge clk);
    @(negedge clk);
    check("ovf_err", err_ovf, 1'b1);
    check("ovf_valid", out_valid, 1'b1);
    held = out_data;
    check("ovf_head", held, 8'hFF);
    idle(3);
    @(negedge clk);
    check("ovf_stall_data", out_data, held);
    check("ovf_stall_last", out_last, 1'b0);
    tick();
    out_ready = 1'b1;
    idle(8);
    for (int i = 0; i < 4; i++) expect_word(8'hFF, 4'd8, 1'b0, 8'd0);
    compare_words("ovf_drain");
    @(negedge clk);
    check("ovf_err_sticky", err_ovf, 1'b1);
    check("ovf_empty", out_valid, 1'b0);

    // reset mid-frame discards the partial word and clears the error
    tick();
    in_valid = 1'b1; in_code = 1'b1;
    tick();
    in_code = 1'b0;
    tick();
    in_code = 1'b1;
    do_reset();
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_err", err_ovf, 1'b0);
    check("midrst_state", state_dbg, 1'b0);
    idle(3);
    compare_words("midrst_none");
    send_frame(64'b11, 2);
    idle(5);
    expect_word(8'hC0, 4'd2, 1'b1, 8'd2);
    compare_words("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
